// File: rtl/ex_mem_stage_buffer.sv
// ex_mem_stage_buffer
//   EX/MEM pipeline register for the LEGv8 core, built as a 2-entry skid buffer.
//   HEAD drives the memory-stage outputs and SKID absorbs one overflow entry.
//   This means in_ready depends only on registered occupancy and never on out_ready.
//   A synchronous flush discards everything held, for example on a branch mispredict.
//   Optional feature: define EXMEM_PERF_CNT_EN to add the stall_count port.
//   stall_count is a saturating count of cycles where the head entry was stalled.
module ex_mem_stage_buffer #(
   parameter int DATA_W     = 64,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_result,
   input  logic                  in_zero,
   input  logic [DATA_W-1:0]     in_store_data,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [CTRL_W-1:0]     in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_result,
   output logic                  out_zero,
   output logic [DATA_W-1:0]     out_store_data,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [CTRL_W-1:0]     out_ctrl
`ifdef EXMEM_PERF_CNT_EN
   ,
   output logic [31:0]           stall_count
`endif
);

   // Payload layout: {result, zero, store_data, rd, ctrl}
   localparam int PAY_W = 2 * DATA_W + 1 + REG_ADDR_W + CTRL_W;

   // Occupancy encoding
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       count_q, count_d;
   logic [PAY_W-1:0] head_q, head_d;
   logic [PAY_W-1:0] skid_q, skid_d;
   logic [PAY_W-1:0] in_pay;
   logic             push;
   logic             pop;

   assign in_pay = {in_result, in_zero, in_store_data, in_rd, in_ctrl};

   // Ready depends only on stored occupancy. It is held low while reset is asserted.
   assign in_ready  = rst_n & (count_q != FULL);
   assign out_valid = (count_q != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign {out_result, out_zero, out_store_data, out_rd, out_ctrl} = head_q;

   // Next occupancy and storage contents. Flush overrides every handshake.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // Dropped entries are zeroed so an empty buffer shows all-zero outputs.
         count_d = EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end else begin
         case (count_q)
            EMPTY: begin
               if (push) begin
                  count_d = ONE;
                  head_d  = in_pay;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  count_d = FULL;
                  skid_d  = in_pay;
               end else if (push && pop) begin
                  // Pass-through: the head is consumed and refilled in the same cycle.
                  head_d = in_pay;
               end else if (!push && pop) begin
                  count_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low in FULL, so only a pop can occur here.
               if (pop) begin
                  count_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: begin
               count_d = EMPTY;
            end
         endcase
      end
   end

   // State and payload registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

`ifdef EXMEM_PERF_CNT_EN
   localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

   logic [31:0] stall_q, stall_d;

   // Count cycles where the head entry waits on the memory stage, saturating at max.
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Stall counter register. Only reset clears it; flush does not.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// tb_ex_mem_stage_buffer
//   Directed bench for the EX/MEM skid buffer.
//   Inputs change 1 ns after a rising edge, and outputs are checked at that same point.
//   Define EXMEM_PERF_CNT_EN to include the stall counter checks.
module tb_ex_mem_stage_buffer;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 4;

   logic                  clk;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_result;
   logic                  in_zero;
   logic [DATA_W-1:0]     in_store_data;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [CTRL_W-1:0]     in_ctrl;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_result;
   logic                  out_zero;
   logic [DATA_W-1:0]     out_store_data;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [CTRL_W-1:0]     out_ctrl;
`ifdef EXMEM_PERF_CNT_EN
   logic [31:0]           stall_count;
`endif

   int n_checks;
   int n_errors;

   ex_mem_stage_buffer #(
      .DATA_W    (DATA_W),
      .REG_ADDR_W(REG_ADDR_W),
      .CTRL_W    (CTRL_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_zero       (in_zero),
      .in_store_data (in_store_data),
      .in_rd         (in_rd),
      .in_ctrl       (in_ctrl),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_zero      (out_zero),
      .out_store_data(out_store_data),
      .out_rd        (out_rd),
      .out_ctrl      (out_ctrl)
`ifdef EXMEM_PERF_CNT_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      in_valid      = 1'b1;
      out_ready     = 1'b0;
      in_result     = 64'h55;
      in_zero       = 1'b0;
      in_store_data = '0;
      in_rd         = '0;
      in_ctrl       = '0;

      // Reset held for 3 cycles while in_valid is high
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
`ifdef EXMEM_PERF_CNT_EN
      check("rst_stall", {32'd0, stall_count}, 64'd0);
`endif

      // Streaming 1, 2, 3 with the consumer always ready
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_result = 64'(i);
         step();
         check("stream_valid", {63'd0, out_valid}, 64'd1);
         check("stream_result", out_result, 64'(i));
         check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain_valid", {63'd0, out_valid}, 64'd0);

      // Backpressure: 0xA then 0xB with the consumer stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 64'hA;
      step();
      check("bp_first_valid", {63'd0, out_valid}, 64'd1);
      check("bp_first_in_ready", {63'd0, in_ready}, 64'd1);
      in_result = 64'hB;
      step();
      check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_full_head", out_result, 64'hA);
      in_valid = 1'b0;
      step();
      check("bp_hold_head", out_result, 64'hA);
      check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      #1;
      check("bp_drain_a", out_result, 64'hA);
      step();
      check("bp_drain_b", out_result, 64'hB);
      check("bp_drain_b_valid", {63'd0, out_valid}, 64'd1);
      check("bp_drain_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      check("bp_empty_valid", {63'd0, out_valid}, 64'd0);

      // Flush from FULL while in_valid presents 0xC
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 64'hA;
      step();
      in_result = 64'hB;
      step();
      check("fl_full_in_ready", {63'd0, in_ready}, 64'd0);
      in_result = 64'hC;
      flush     = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", {63'd0, out_valid}, 64'd0);
      check("fl_in_ready", {63'd0, in_ready}, 64'd1);
      check("fl_result_zero", out_result, 64'd0);
      out_ready = 1'b1;
      step();
      check("fl_no_c_valid", {63'd0, out_valid}, 64'd0);
      check("fl_no_c_result", out_result, 64'd0);

      // Flush in ONE drops an accepted same-cycle push
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 64'h11;
      step();
      in_result = 64'h22;
      flush     = 1'b1;
      #1;
      check("fl1_in_ready_pre", {63'd0, in_ready}, 64'd1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl1_valid", {63'd0, out_valid}, 64'd0);
      step();
      check("fl1_still_empty", {63'd0, out_valid}, 64'd0);

      // Field integrity
      in_valid      = 1'b1;
      in_result     = 64'd0;
      in_zero       = 1'b1;
      in_rd         = 5'd31;
      in_ctrl       = 4'b0110;
      in_store_data = 64'hDEAD_BEEF_0000_0001;
      step();
      in_valid = 1'b0;
      check("fld_valid", {63'd0, out_valid}, 64'd1);
      check("fld_result", out_result, 64'd0);
      check("fld_zero", {63'd0, out_zero}, 64'd1);
      check("fld_rd", {59'd0, out_rd}, 64'd31);
      check("fld_ctrl", {60'd0, out_ctrl}, 64'h6);
      check("fld_store", out_store_data, 64'hDEAD_BEEF_0000_0001);
      out_ready = 1'b1;
      step();
      check("fld_drain_valid", {63'd0, out_valid}, 64'd0);

      // Stall counter: 7 stalled cycles, flush keeps the count, reset clears it
      do_reset();
      #1;
      check("pc_reset_valid", {63'd0, out_valid}, 64'd0);
`ifdef EXMEM_PERF_CNT_EN
      check("pc_start", {32'd0, stall_count}, 64'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 64'h77;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("pc_seven", {32'd0, stall_count}, 64'd7);
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      check("pc_after_flush", {32'd0, stall_count}, 64'd7);
      step();
      check("pc_idle", {32'd0, stall_count}, 64'd7);
      do_reset();
      #1;
      check("pc_cleared", {32'd0, stall_count}, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
